spi_response_assembler: RTL
===========================

Name: spi_response_assembler

Overview:
Downstream companion to the SPI command encoder. It watches the byte stream returned by the SPI master for each IMU read command (roll, pitch or yaw; angular or linear). It extracts the low and high data bytes, which arrive in two 2-byte register transactions, and assembles them into one 16-bit signed sample tagged with its command code. It presents the sample on a valid/ready interface to the attitude-processing logic, with sticky error reporting for overrun, timeout and protocol errors.

Parameters:
TIMEOUT_CYCLES, 4096, clk cycles allowed between command start / accepted data byte and the next accepted data byte before abort
TO_W, 13, width of timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
cmd_start  input  1  one-cycle pulse: encoder accepted a command (same cycle as encoder transmit)
cmd_code  input  3  command code, sampled on cmd_start; 0..5 valid (ROLLANG, ROLLLIN, PITCHANG, PITCHLIN, YAWANG, YAWLIN)
rx_dv  input  1  one-cycle strobe from SPI master: rx_byte valid
rx_byte  input  8  received byte
rx_count  input  2  byte index within the current SPI transaction; 0 = address-phase echo, 1 = data byte
sample_data  output  16  assembled sample {high, low}, two's complement
sample_cmd  output  3  command code of sample_data
sample_valid  output  1  output register holds an unconsumed sample
sample_ready  input  1  consumer accepts the sample when valid && ready
busy  output  1  state != IDLE
clear_flags  input  1  synchronous clear of sticky flags and drop_count
overrun  output  1  sticky: assembled sample dropped because output register was full
timeout  output  1  sticky: transaction aborted by timeout
cmd_err  output  1  sticky: cmd_start while busy, or cmd_code > 5
drop_count  output  8  saturating count of dropped samples (holds at 255)

Behaviour:
- Reset (async, rst_n low) clears all outputs to 0: sample_data, sample_cmd, sample_valid, busy, overrun, timeout, cmd_err, drop_count. State = IDLE, timer = 0, internal low-byte register = 0.
- FSM states: IDLE, WAIT_LO, WAIT_HI. All registers update on the rising clk edge.
- IDLE:
  - cmd_start with cmd_code <= 5: latch cmd_code, clear timer, go to WAIT_LO.
  - cmd_start with cmd_code > 5: set cmd_err, stay in IDLE.
  - rx_dv in IDLE is ignored.
- WAIT_LO:
  - rx_dv && rx_count==1: store rx_byte as low byte, clear timer, go to WAIT_HI.
  - rx_dv with rx_count 0, 2 or 3: byte discarded, no timer clear.
- WAIT_HI:
  - rx_dv && rx_count==1: commit {rx_byte, low}, return to IDLE.
  - Other rx_count values: discarded.
- Commit: if sample_valid==0, or sample_valid && sample_ready in the same cycle, load sample_data/sample_cmd and assert sample_valid on the next cycle. Latency is 1 clk from the high-byte rx_dv. Otherwise the new sample is dropped, overrun is set and drop_count increments (saturating at 255); the existing output is held.
- Output handshake:
  - sample_valid falls on the cycle after valid && ready unless a commit reloads it in that same cycle.
  - sample_data and sample_cmd are stable while sample_valid && !ready.
  - The consumer may hold ready high continuously.
- Timer:
  - Increments every cycle in WAIT_LO/WAIT_HI without an accepted data byte.
  - When it reaches TIMEOUT_CYCLES-1: set timeout, discard the partial sample, go to IDLE next cycle.
  - An accepted data byte in the same cycle as expiry takes priority; no timeout occurs.
- cmd_start while busy: ignored (the transaction continues) and cmd_err is set.
- Flag clearing: clear_flags clears overrun, timeout, cmd_err and drop_count. A set or increment event in the same cycle wins: the flag ends at 1 and drop_count at 1.
- Sample output is unaffected by clear_flags.
- Reset mid-transaction aborts immediately. The partial byte is lost and no sample is produced.

Test Plan:
- Nominal ROLLANG: cmd_start with cmd_code=0, then rx sequence (cnt0, 0xFF), (cnt1, 0x34), (cnt0, 0xFF), (cnt1, 0x12), ready=1 -> one cycle after the last rx_dv, sample_valid=1, sample_data=0x1234, sample_cmd=0, then busy=0.
- Backpressure/overrun: ready=0, two complete YAWLIN commands with data 0x8001 then 0x7FFF -> output holds 0x8001 (cmd 5), overrun=1, drop_count=1. Raising ready consumes 0x8001 and sample_valid=0.
- Simultaneous consume and commit: sample pending, high byte arrives in the same cycle as ready=1 -> new sample loaded, sample_valid stays 1, overrun=0.
- Timeout: TIMEOUT_CYCLES=16, cmd_start, low byte only -> timeout=1 sixteen cycles later, state IDLE, no sample_valid. A following full command assembles correctly.
- Protocol errors: cmd_code=6 -> cmd_err=1, busy stays 0. cmd_start during WAIT_HI -> cmd_err=1 and the original sample completes with its original sample_cmd. clear_flags together with a new overrun -> overrun=1, drop_count=1.
- Reset mid-operation: rst_n low for one cycle in WAIT_HI -> all outputs 0 immediately; subsequent rx bytes without cmd_start produce no sample.

Source files
------------

// File: rtl/spi_response_assembler_if.sv
// Bundle between the SPI command/receive side, the sample consumer and the
// flag/status observer of the response assembler.
interface spi_response_assembler_if;
    logic        cmd_start;
    logic [2:0]  cmd_code;
    logic        rx_dv;
    logic [7:0]  rx_byte;
    logic [1:0]  rx_count;
    logic [15:0] sample_data;
    logic [2:0]  sample_cmd;
    logic        sample_valid;
    logic        sample_ready;
    logic        busy;
    logic        clear_flags;
    logic        overrun;
    logic        timeout;
    logic        cmd_err;
    logic [7:0]  drop_count;

    modport slave (
        input  cmd_start, cmd_code, rx_dv, rx_byte, rx_count, sample_ready, clear_flags,
        output sample_data, sample_cmd, sample_valid, busy, overrun, timeout, cmd_err, drop_count
    );

    modport master (
        output cmd_start, cmd_code, rx_dv, rx_byte, rx_count, sample_ready, clear_flags,
        input  sample_data, sample_cmd, sample_valid, busy, overrun, timeout, cmd_err, drop_count
    );
endinterface

// File: rtl/spi_response_assembler.sv
// Collects the low/high data bytes of an IMU register read into one signed
// 16-bit sample tagged with its command code, with sticky error reporting.
module spi_response_assembler #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_W           = 13
) (
    input  logic                      clk,
    input  logic                      rst_n,
    spi_response_assembler_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_HI} state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t          r_state, w_next;
    logic [TO_W-1:0] r_timer, w_timer_nx;
    logic [7:0]      r_lo;
    logic [2:0]      r_cmd_lat;
    logic [15:0]     r_data;
    logic [2:0]      r_cmd;
    logic            r_valid;
    logic            r_overrun, r_timeout, r_cmd_err;
    logic [7:0]      r_drop;

    logic w_data_acc, w_lo_load, w_commit, w_to_ev, w_err_ev, w_latch_cmd;
    logic w_can_load, w_drop;

    // Only the data byte (index 1) of each 2-byte transaction carries payload.
    assign w_data_acc = bus.rx_dv && (bus.rx_count == 2'd1);
    assign w_err_ev   = bus.cmd_start && ((r_state != IDLE) || (bus.cmd_code > 3'd5));
    assign w_can_load = !r_valid || bus.sample_ready;
    assign w_drop     = w_commit && !w_can_load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timer_nx;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_timer_nx  = r_timer;
        w_lo_load   = 1'b0;
        w_commit    = 1'b0;
        w_to_ev     = 1'b0;
        w_latch_cmd = 1'b0;
        case (r_state)
            IDLE: begin
                w_timer_nx = '0;
                if (bus.cmd_start && (bus.cmd_code <= 3'd5)) begin
                    w_latch_cmd = 1'b1;
                    w_next      = WAIT_LO;
                end
            end
            WAIT_LO, WAIT_HI: begin
                // An accepted byte beats expiry in the same cycle.
                if (w_data_acc) begin
                    w_timer_nx = '0;
                    if (r_state == WAIT_LO) begin
                        w_lo_load = 1'b1;
                        w_next    = WAIT_HI;
                    end else begin
                        w_commit  = 1'b1;
                        w_next    = IDLE;
                    end
                end else if (r_timer == TO_LAST) begin
                    w_to_ev    = 1'b1;
                    w_timer_nx = '0;
                    w_next     = IDLE;
                end else begin
                    w_timer_nx = r_timer + 1'b1;
                end
            end
            default: begin
                w_next     = IDLE;
                w_timer_nx = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lo      <= '0;
            r_cmd_lat <= '0;
        end else begin
            if (w_lo_load)   r_lo      <= bus.rx_byte;
            if (w_latch_cmd) r_cmd_lat <= bus.cmd_code;
        end
    end

    // Output register: a commit may reload in the same cycle the old sample is consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data  <= '0;
            r_cmd   <= '0;
            r_valid <= 1'b0;
        end else if (w_commit && w_can_load) begin
            r_data  <= {bus.rx_byte, r_lo};
            r_cmd   <= r_cmd_lat;
            r_valid <= 1'b1;
        end else if (r_valid && bus.sample_ready) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky flags: a same-cycle event overrides clear_flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
            r_cmd_err <= 1'b0;
            r_drop    <= '0;
        end else begin
            r_overrun <= w_drop   || (r_overrun && !bus.clear_flags);
            r_timeout <= w_to_ev  || (r_timeout && !bus.clear_flags);
            r_cmd_err <= w_err_ev || (r_cmd_err && !bus.clear_flags);
            if (w_drop) begin
                if (bus.clear_flags)      r_drop <= 8'd1;
                else if (r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
            end else if (bus.clear_flags) begin
                r_drop <= '0;
            end
        end
    end

    assign bus.sample_data  = r_data;
    assign bus.sample_cmd   = r_cmd;
    assign bus.sample_valid = r_valid;
    assign bus.busy         = (r_state != IDLE);
    assign bus.overrun      = r_overrun;
    assign bus.timeout      = r_timeout;
    assign bus.cmd_err      = r_cmd_err;
    assign bus.drop_count   = r_drop;
endmodule
